// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encodings and bus constants for cpu_memory
package mem_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // mem_rw polarity, shared with the core's data-port decoder
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - 2^DEPTH_LOG2 x 32 storage, one sync write port, two async read ports
module ram_array #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr0_i,
  output logic [31:0]           rdata0_o,
  input  logic [DEPTH_LOG2-1:0] raddr1_i,
  output logic [31:0]           rdata1_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  // No reset: the INIT sweep in the parent clears every word
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Async reads see the pre-edge contents, giving read-before-write
  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/cpu_memory.sv
// rtl/cpu_memory.sv - unified instruction/data memory with clear, load and run phases
module cpu_memory #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_WORD   = mem_pkg::NOP_WORD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           inst_ain,
  output logic [31:0]           inst_dout,
  input  logic                  mem_rw,
  input  logic [31:0]           mem_ain,
  input  logic [31:0]           mem_din,
  output logic [31:0]           mem_dout,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [31:0]           load_addr,
  input  logic [31:0]           load_data,
  input  logic                  load_done,
  output logic                  ready,
  output logic [DEPTH_LOG2-1:0] init_count
);

  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = {DEPTH_LOG2{1'b1}};

  mem_pkg::state_e state_q, state_d;
  logic [DEPTH_LOG2-1:0] count_q, count_d;

  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [31:0]           wdata;
  logic [31:0]           inst_rdata;
  logic [31:0]           mem_rdata;
  logic                  in_run;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= mem_pkg::ST_INIT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = '0;
    case (state_q)
      mem_pkg::ST_INIT: begin
        count_d = count_q + 1'b1;
        if (count_q == LAST_ADDR) begin
          state_d = mem_pkg::ST_LOAD;
        end
      end
      mem_pkg::ST_LOAD: begin
        if (load_done) begin
          state_d = mem_pkg::ST_RUN;
        end
      end
      mem_pkg::ST_RUN: state_d = mem_pkg::ST_RUN;
      default:         state_d = mem_pkg::ST_INIT;
    endcase
  end

  // Write-port mux: sweep, loader or core, selected by phase
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    case (state_q)
      mem_pkg::ST_INIT: begin
        we    = 1'b1;
        waddr = count_q;
      end
      mem_pkg::ST_LOAD: begin
        we    = load_valid;
        waddr = load_addr[DEPTH_LOG2-1:0];
        wdata = load_data;
      end
      mem_pkg::ST_RUN: begin
        we    = (mem_rw == mem_pkg::MEM_WRITE);
        waddr = mem_ain[DEPTH_LOG2-1:0];
        wdata = mem_din;
      end
      default: we = 1'b0;
    endcase
    if (reset) begin
      we = 1'b0;
    end
  end

  ram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clock    (clock),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .raddr0_i (inst_ain[DEPTH_LOG2-1:0]),
    .rdata0_o (inst_rdata),
    .raddr1_i (mem_ain[DEPTH_LOG2-1:0]),
    .rdata1_o (mem_rdata)
  );

  always_comb begin
    in_run     = (state_q == mem_pkg::ST_RUN);
    ready      = in_run;
    load_ready = (state_q == mem_pkg::ST_LOAD);
    init_count = (state_q == mem_pkg::ST_INIT) ? count_q : '0;
    inst_dout  = in_run ? inst_rdata : NOP_WORD;
    mem_dout   = in_run ? mem_rdata : 32'h0;
  end

endmodule

// File: doc/cpu_memory.md
# cpu_memory

Word-addressed unified memory serving the `cpu` core's instruction-fetch and data ports. It is the responder end of both buses: it returns the word at `inst_aout` and `mem_aout` within the same cycle, and commits stores on the clock edge. After reset it runs a three-state sequence. It first clears the array, then accepts a program image over a valid/ready loader port, then serves the core. `ready` gates the core's release from reset.

## Interface
- `DEPTH_LOG2`, default 10: array holds 2^DEPTH_LOG2 32-bit words.
- `NOP_WORD`, default 32'h0000_0013: value returned on `inst_dout` whenever the block is not in RUN.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `inst_ain`  in  32  fetch word address, driven from the core's `inst_aout`.
- `inst_dout`  out  32  fetched word, connected to the core's `inst_din`.
- `mem_rw`  in  1  1 = write, 0 = read.
- `mem_ain`  in  32  data word address.
- `mem_din`  in  32  store data, from the core's `mem_dout`.
- `mem_dout`  out  32  load data, to the core's `mem_din`.
- `load_valid`  in  1  loader word present.
- `load_ready`  out  1  loader word accepted this cycle when high together with `load_valid`.
- `load_addr`  in  32  loader word address.
- `load_data`  in  32  loader word.
- `load_done`  in  1  loader signals that the image is complete.
- `ready`  out  1  high only in RUN; releases the core.
- `init_count`  out  DEPTH_LOG2  sweep address during INIT. It reads 0 in other states.

## Operation
- Address index = `addr[DEPTH_LOG2-1:0]` on every port. Upper bits are ignored, so addresses alias modulo depth. No fault is raised.
- The array has one write port and two asynchronous read ports.
- **INIT** (entered on reset)
  - Writes 0 to word `init_count` each cycle, then increments `init_count`.
  - After writing word 2^DEPTH_LOG2-1, moves to LOAD. The sweep takes exactly 2^DEPTH_LOG2 cycles.
- **LOAD**
  - `load_ready`=1.
  - A handshake (`load_valid`&`load_ready`) writes `load_data` to `load_addr` on that edge.
  - `load_done` sampled high moves to RUN on that edge. If `load_valid` is also high on that edge, the word is still written.
  - Repeated writes to one address: the last one wins.
- **RUN**
  - `mem_rw`=1 writes `mem_din` to `mem_ain` on the edge.
  - `load_*` inputs are ignored; `load_ready`=0.
  - RUN is left only by reset.
- **Outside RUN**
  - `inst_dout`=`NOP_WORD`, `mem_dout`=0.
  - `mem_rw` is ignored.
- **Reads**
  - `inst_dout` and `mem_dout` are combinational from the array.
  - A read in the same cycle as a write to the same address returns the old word. The new word is visible from the next cycle (read-before-write).
  - Fetch and data reads of the same or different addresses proceed concurrently, with no arbitration.
- **Reset mid-operation**
  - Any state returns to INIT with `init_count`=0 and the sweep restarts.
  - Any image loaded earlier is cleared.

## Timing
- Outputs during reset and in the first INIT cycle: `ready`=0, `load_ready`=0, `init_count`=0, `inst_dout`=`NOP_WORD`, `mem_dout`=0.
- Read latency is 0 cycles on both ports. Write latency is 1 edge.
- Reset to LOAD takes 2^DEPTH_LOG2 cycles.
- `ready` rises on the edge that samples `load_done`. The core's first fetch is on the following cycle.
- State encoding: INIT=2'd0, LOAD=2'd1, RUN=2'd2. The value 2'd3 is illegal and must recover to INIT on the next edge.

## Structure
- Shared package `mem_pkg` holds:
  - the state encodings;
  - `NOP_WORD`;
  - the polarity constants `MEM_READ`=0 and `MEM_WRITE`=1, shared with the core's mem decoder.
- One sub-module, `ram_array`, contains the 2^DEPTH_LOG2 x 32 storage with one synchronous write port and two asynchronous read ports.
- The top level holds:
  - the FSM;
  - the sweep counter;
  - the write-port mux, which selects the INIT sweep, loader or core write by state.

## Test plan
- **Reset and sweep (DEPTH_LOG2=4)**
  - Reset for 1 cycle, then hold `load_done`=0.
  - `ready`=0 and `inst_dout`=32'h13 for 16 cycles.
  - `load_ready` rises on cycle 16.
  - `init_count` steps 0..15.
- **Load then run**
  - Load 32'hDEAD_BEEF at address 3 and 32'h0000_0093 at address 0, then pulse `load_done`.
  - Next cycle `ready`=1.
  - `inst_ain`=0 gives 32'h93; `inst_ain`=3 gives 32'hDEAD_BEEF.
  - Every other address reads 0.
- **Store and read-before-write**
  - In RUN, drive `mem_rw`=1, `mem_ain`=5, `mem_din`=32'h1234_5678.
  - Same cycle: `mem_dout`=0.
  - Next cycle, with `mem_rw`=0: `mem_dout`=32'h1234_5678, and `inst_ain`=5 also gives 32'h1234_5678.
- **Aliasing**
  - Write 32'hA5 at address 32'h0000_0015 (DEPTH_LOG2=4).
  - Reading address 5 returns 32'hA5.
- **Ignored traffic**
  - In LOAD, drive `mem_rw`=1 to address 2; in RUN, drive `load_valid`=1 to address 2.
  - Address 2 stays 0 and `load_ready`=0 in RUN.
  - `load_done` together with `load_valid` still writes that final word.
- **Mid-run reset**
  - Assert reset in RUN after writing address 5.
  - `ready` drops on the next edge and the sweep restarts at 0.
  - After the new load and `load_done`, address 5 reads 0.
